// File: rtl/eda_neighbor_pusher_pkg.sv
// -----------------------------------------------------------------------------
// eda_neighbor_pusher_pkg
// Shared definitions for the regional-max flood-fill producer:
//   - raster-order neighbour index constants NB_NW .. NB_SE
//   - (dr, dc) offset table as 2-bit two's-complement values
//   - default image / FIFO configuration
// -----------------------------------------------------------------------------
package eda_neighbor_pusher_pkg;

    localparam int NB_NW = 0;
    localparam int NB_N  = 1;
    localparam int NB_NE = 2;
    localparam int NB_W  = 3;
    localparam int NB_E  = 4;
    localparam int NB_SW = 5;
    localparam int NB_S  = 6;
    localparam int NB_SE = 7;

    localparam int CFG_IMG_ROWS   = 128;
    localparam int CFG_IMG_COLS   = 128;
    localparam int CFG_FIFO_DEPTH = 16;

    // Row offset of neighbour k: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
    function automatic logic [1:0] nb_dr(input int k);
        case (k)
            NB_NW, NB_N, NB_NE: nb_dr = 2'b11;
            NB_W, NB_E:         nb_dr = 2'b00;
            NB_SW, NB_S, NB_SE: nb_dr = 2'b01;
            default:            nb_dr = 2'b00;
        endcase
    endfunction

    // Column offset of neighbour k: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
    function automatic logic [1:0] nb_dc(input int k);
        case (k)
            NB_NW, NB_W, NB_SW: nb_dc = 2'b11;
            NB_N, NB_S:         nb_dc = 2'b00;
            NB_NE, NB_E, NB_SE: nb_dc = 2'b01;
            default:            nb_dc = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/eda_addr_fifo.sv
// -----------------------------------------------------------------------------
// eda_addr_fifo
// First-word-fall-through FIFO used once per neighbour position.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous flush (wins over push/pop)
//   push, din    : write request and data
//   pop          : read request; dout already shows the head (FWFT)
//   dout         : head entry, forced to 0 while empty
//   empty, full  : occupancy flags decoded from the count register
// A pop on an empty FIFO is ignored. A push to a full FIFO is accepted only
// when a pop frees a slot on the same edge; otherwise it is dropped.
// -----------------------------------------------------------------------------
module eda_addr_fifo #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    assign empty     = (count_q == {CNT_W{1'b0}});
    assign full      = (count_q == CNT_FULL);
    assign pop_ok_s  = pop & ~empty;
    // Pop frees its slot first, so a full FIFO still takes a same-edge push.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = empty ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/eda_neighbor_pusher.sv
// -----------------------------------------------------------------------------
// eda_neighbor_pusher
// Producer side of the regional-max flood-fill queue. Qualifies the eight
// neighbours of the current 3x3 window, pushes equal-valued, unvisited,
// in-image neighbour addresses into per-position FWFT FIFOs and serves them
// back. Tracks whether the current plateau touches a strictly greater pixel.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   clear             : synchronous flush of FIFOs and sticky flags
//   new_pixel         : window inputs valid this cycle
//   center_addr       : {row, col} of the centre pixel
//   update_strb       : a new seed region starts this cycle
//   center_pixel      : centre value
//   nbr_pixels        : neighbour k value at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   visited           : neighbour k already visited or queued
//   read_en           : one-hot or zero FIFO pop select
//   push_positions    : neighbours pushed this cycle (combinational)
//   fifo_empty        : per-FIFO empty flag
//   data_out          : head of the FIFO selected by read_en, 0 if none
//   seed_not_max      : sticky, region has a strictly greater neighbour
//   overflow          : sticky, a push was dropped on a full FIFO
// -----------------------------------------------------------------------------
module eda_neighbor_pusher
    import eda_neighbor_pusher_pkg::*;
#(
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int I_WIDTH      = 7,
    parameter int J_WIDTH      = 7,
    parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH,
    parameter int IMG_ROWS     = CFG_IMG_ROWS,
    parameter int IMG_COLS     = CFG_IMG_COLS,
    parameter int FIFO_DEPTH   = CFG_FIFO_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   clear,
    input  logic                                   new_pixel,
    input  logic [ADDR_WIDTH-1:0]                  center_addr,
    input  logic                                   update_strb,
    input  logic [PIXEL_WIDTH-1:0]                 center_pixel,
    input  logic [(WINDOW_WIDTH-1)*PIXEL_WIDTH-1:0] nbr_pixels,
    input  logic [WINDOW_WIDTH-2:0]                visited,
    input  logic [WINDOW_WIDTH-2:0]                read_en,
    output logic [WINDOW_WIDTH-2:0]                push_positions,
    output logic [WINDOW_WIDTH-2:0]                fifo_empty,
    output logic [ADDR_WIDTH-1:0]                  data_out,
    output logic                                   seed_not_max,
    output logic                                   overflow
);

    localparam int NB = WINDOW_WIDTH - 1;
    // Bounds are compared one bit wider than the index so that -1 becomes
    // a large value rather than wrapping to the last row/column.
    localparam logic [I_WIDTH:0] ROW_MAX = (I_WIDTH + 1)'(IMG_ROWS - 1);
    localparam logic [J_WIDTH:0] COL_MAX = (J_WIDTH + 1)'(IMG_COLS - 1);

    logic [I_WIDTH-1:0]    row_s;
    logic [J_WIDTH-1:0]    col_s;
    logic [NB-1:0]         push_s;
    logic [NB-1:0]         gt_vec_s;
    logic [NB-1:0]         full_s;
    logic [NB-1:0]         drop_s;
    logic [ADDR_WIDTH-1:0] head_sel_s [NB];
    logic                  gt_any_s;
    logic                  seed_not_max_q, seed_not_max_d;
    logic                  overflow_q, overflow_d;

    assign row_s = center_addr[ADDR_WIDTH-1:J_WIDTH];
    assign col_s = center_addr[J_WIDTH-1:0];

    for (genvar k = 0; k < NB; k++) begin : gen_nbr
        localparam logic [1:0] DR = nb_dr(k);
        localparam logic [1:0] DC = nb_dc(k);

        logic [I_WIDTH:0]      r_ext_s;
        logic [J_WIDTH:0]      c_ext_s;
        logic                  in_bounds_s;
        logic [PIXEL_WIDTH-1:0] pix_s;
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [ADDR_WIDTH-1:0] dout_s;

        assign r_ext_s     = {1'b0, row_s} + {{(I_WIDTH - 1){DR[1]}}, DR};
        assign c_ext_s     = {1'b0, col_s} + {{(J_WIDTH - 1){DC[1]}}, DC};
        assign in_bounds_s = (r_ext_s <= ROW_MAX) && (c_ext_s <= COL_MAX);
        assign addr_s      = {r_ext_s[I_WIDTH-1:0], c_ext_s[J_WIDTH-1:0]};
        assign pix_s       = nbr_pixels[k*PIXEL_WIDTH +: PIXEL_WIDTH];

        assign push_s[k]   = new_pixel & ~clear & in_bounds_s & ~visited[k]
                           & (pix_s == center_pixel);
        assign gt_vec_s[k] = in_bounds_s & (pix_s > center_pixel);
        // A full FIFO is never empty, so read_en alone means a real pop.
        assign drop_s[k]   = push_s[k] & full_s[k] & ~read_en[k];

        eda_addr_fifo #(
            .DATA_WIDTH (ADDR_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (clear),
            .push    (push_s[k]),
            .pop     (read_en[k]),
            .din     (addr_s),
            .dout    (dout_s),
            .empty   (fifo_empty[k]),
            .full    (full_s[k])
        );

        assign head_sel_s[k] = read_en[k] ? dout_s : {ADDR_WIDTH{1'b0}};
    end

    assign push_positions = push_s;
    assign gt_any_s       = new_pixel & (|gt_vec_s);
    assign seed_not_max   = seed_not_max_q;
    assign overflow       = overflow_q;

    // OR of the selected heads; read_en is expected to be one-hot or zero.
    always_comb begin
        data_out = {ADDR_WIDTH{1'b0}};
        for (int k = 0; k < NB; k++) begin
            data_out = data_out | head_sel_s[k];
        end
    end

    // Sticky flag next-state; a new seed restarts the greater-neighbour flag.
    always_comb begin
        seed_not_max_d = seed_not_max_q;
        overflow_d     = overflow_q;
        if (clear) begin
            seed_not_max_d = 1'b0;
            overflow_d     = 1'b0;
        end else if (update_strb) begin
            seed_not_max_d = gt_any_s;
            overflow_d     = overflow_q | (|drop_s);
        end else begin
            seed_not_max_d = seed_not_max_q | gt_any_s;
            overflow_d     = overflow_q | (|drop_s);
        end
    end

    // Sticky flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seed_not_max_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            seed_not_max_q <= seed_not_max_d;
            overflow_q     <= overflow_d;
        end
    end

endmodule

// File: tb/tb_eda_neighbor_pusher.sv
module tb_eda_neighbor_pusher;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        new_pixel;
    logic [13:0] center_addr;
    logic        update_strb;
    logic [7:0]  center_pixel;
    logic [63:0] nbr_pixels;
    logic [7:0]  visited;
    logic [7:0]  read_en;
    logic [7:0]  push_positions;
    logic [7:0]  fifo_empty;
    logic [13:0] data_out;
    logic        seed_not_max;
    logic        overflow;

    always #5 clk = ~clk;

    eda_neighbor_pusher dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (clear),
        .new_pixel      (new_pixel),
        .center_addr    (center_addr),
        .update_strb    (update_strb),
        .center_pixel   (center_pixel),
        .nbr_pixels     (nbr_pixels),
        .visited        (visited),
        .read_en        (read_en),
        .push_positions (push_positions),
        .fifo_empty     (fifo_empty),
        .data_out       (data_out),
        .seed_not_max   (seed_not_max),
        .overflow       (overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            assert ($onehot0(read_en)) else $error("read_en not onehot0: %b", read_en);
        end
    end

    // Reference model: one queue per neighbour position.
    logic [13:0] mq [8][$];
    bit          m_ovf;
    bit          m_snm;
    int          DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int          DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0]  e_push;
    bit          e_gt;
    logic [13:0] e_addr [8];

    function automatic void model_eval();
        int row, col, r, c;
        bit inb;
        logic [7:0] p;
        row = int'(center_addr[13:7]);
        col = int'(center_addr[6:0]);
        e_push = 8'h00;
        e_gt   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r = row + DR[k];
            c = col + DC[k];
            inb = (r >= 0) && (r < 128) && (c >= 0) && (c < 128);
            p = nbr_pixels[k*8 +: 8];
            e_addr[k] = inb ? 14'(r * 128 + c) : 14'h0;
            e_push[k] = new_pixel && !clear && inb && !visited[k] && (p == center_pixel);
            if (new_pixel && inb && (p > center_pixel)) e_gt = 1'b1;
        end
    endfunction

    function automatic void model_flush();
        for (int k = 0; k < 8; k++) mq[k].delete();
        m_ovf = 1'b0;
        m_snm = 1'b0;
    endfunction

    // Compare every output against the model, then advance one clock.
    task automatic step();
        int sel;
        logic [13:0] exp_d;
        logic [7:0]  exp_e;
        model_eval();
        sel = -1;
        for (int k = 0; k < 8; k++) if (read_en[k]) sel = k;
        exp_d = (sel >= 0 && mq[sel].size() > 0) ? mq[sel][0] : 14'h0;
        for (int k = 0; k < 8; k++) exp_e[k] = (mq[k].size() == 0);
        chk_val("push", push_positions, e_push);
        chk_val("data", data_out, exp_d);
        chk_val("empty", fifo_empty, exp_e);
        chk_val("ovf", overflow, m_ovf);
        chk_val("snm", seed_not_max, m_snm);
        @(posedge clk);
        if (clear) begin
            model_flush();
        end else begin
            for (int k = 0; k < 8; k++)
                if (read_en[k] && mq[k].size() > 0) void'(mq[k].pop_front());
            for (int k = 0; k < 8; k++) begin
                if (e_push[k]) begin
                    if (mq[k].size() < 16) mq[k].push_back(e_addr[k]);
                    else m_ovf = 1'b1;
                end
            end
            m_snm = update_strb ? e_gt : (m_snm | e_gt);
        end
        #1;
    endtask

    task automatic apply(input int row, input int col, input logic [7:0] cp, input logic [63:0] nb,
                         input logic [7:0] vis, input logic np, input logic us, input logic clr,
                         input logic [7:0] re);
        center_addr  = {row[6:0], col[6:0]};
        center_pixel = cp;
        nbr_pixels   = nb;
        visited      = vis;
        new_pixel    = np;
        update_strb  = us;
        clear        = clr;
        read_en      = re;
        #2;
    endtask

    task automatic idle(input logic [7:0] re);
        apply(0, 0, 8'd0, 64'd0, 8'h00, 1'b0, 1'b0, 1'b0, re);
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 17; n++) begin
                idle(8'(1 << k));
                step();
            end
        end
        idle(8'h00);
        chk_val("drain_empty", fifo_empty, 8'hFF);
        step();
    endtask

    // Push only into FIFO 4 (E) from centre (row, col).
    task automatic push_east(input int row, input int col);
        logic [63:0] nb;
        nb = {8{8'd40}};
        nb[39:32] = 8'd50;
        apply(row, col, 8'd50, nb, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
    endtask

    initial begin
        logic [63:0] nb;
        int row, col;
        logic [7:0] cp;
        logic [7:0] vis;
        logic [7:0] re;

        reset_n = 1'b0;
        model_flush();
        idle(8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        idle(8'h00);
        chk_val("rst_empty", fifo_empty, 8'hFF);
        chk_val("rst_data", data_out, 14'h0);
        chk_val("rst_push", push_positions, 8'h00);
        chk_val("rst_snm", seed_not_max, 1'b0);
        chk_val("rst_ovf", overflow, 1'b0);
        step();

        // Interior flat patch at (5,5)
        apply(5, 5, 8'd50, {8{8'd50}}, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_val("flat_push", push_positions, 8'hFF);
        step();
        idle(8'h00);
        chk_val("flat_empty", fifo_empty, 8'h00);
        step();
        idle(8'h80);
        chk_val("flat_se", data_out, {7'd6, 7'd6});
        step();
        drain();

        // Corner (0,0)
        apply(0, 0, 8'd50, {8{8'd50}}, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        chk_val("corner_push", push_positions, 8'hD0);
        step();
        idle(8'h10);
        chk_val("corner_e", data_out, {7'd0, 7'd1});
        step();
        idle(8'h40);
        chk_val("corner_s", data_out, {7'd1, 7'd0});
        step();
        idle(8'h80);
        chk_val("corner_se", data_out, {7'd1, 7'd1});
        step();
        drain();

        // Greater neighbour
        nb = {8{8'd100}};
        nb[15:8] = 8'd101;
        apply(20, 20, 8'd100, nb, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        idle(8'h00);
        chk_val("gt_set", seed_not_max, 1'b1);
        step();
        apply(20, 21, 8'd100, {8{8'd100}}, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        idle(8'h00);
        chk_val("gt_sticky", seed_not_max, 1'b1);
        step();
        apply(30, 30, 8'd100, {8{8'd90}}, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        idle(8'h00);
        chk_val("gt_restart", seed_not_max, 1'b0);
        step();

        // Overflow on FIFO 4
        for (int j = 0; j < 17; j++) push_east(10, j);
        idle(8'h00);
        chk_val("ovf_set", overflow, 1'b1);
        step();
        for (int j = 0; j < 16; j++) begin
            idle(8'h10);
            chk_val("ovf_order", data_out, {7'd10, 7'(j + 1)});
            step();
        end
        idle(8'h00);
        chk_val("ovf_drained", fifo_empty, 8'hFF);
        step();

        // Clear mid-fill
        for (int j = 0; j < 5; j++) push_east(40, j);
        apply(5, 5, 8'd50, {8{8'd50}}, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
        chk_val("clr_push", push_positions, 8'h00);
        step();
        idle(8'h10);
        chk_val("clr_empty", fifo_empty, 8'hFF);
        chk_val("clr_ovf", overflow, 1'b0);
        chk_val("clr_data", data_out, 14'h0);
        step();

        // Simultaneous push and pop on FIFO 0
        nb = 64'd0;
        nb[7:0] = 8'd60;
        apply(3, 3, 8'd60, nb, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        step();
        apply(4, 4, 8'd60, nb, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01);
        chk_val("sim_old", data_out, {7'd2, 7'd2});
        step();
        idle(8'h01);
        chk_val("sim_empty0", fifo_empty[0], 1'b0);
        chk_val("sim_new", data_out, {7'd3, 7'd3});
        step();

        // Asynchronous reset mid-fill
        for (int j = 0; j < 5; j++) push_east(50, j);
        idle(8'h00);
        reset_n = 1'b0;
        #1;
        chk_val("arst_empty", fifo_empty, 8'hFF);
        read_en = 8'h10;
        #1;
        chk_val("arst_data", data_out, 14'h0);
        chk_val("arst_ovf", overflow, 1'b0);
        model_flush();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) row = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) : $urandom_range(126, 127);
            else row = $urandom_range(0, 127);
            if ($urandom_range(0, 2) == 0) col = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) : $urandom_range(126, 127);
            else col = $urandom_range(0, 127);
            cp = 8'($urandom_range(1, 254));
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(0, 4))
                    0:       nb[k*8 +: 8] = cp - 8'd1;
                    1:       nb[k*8 +: 8] = cp + 8'd1;
                    default: nb[k*8 +: 8] = cp;
                endcase
                vis[k] = ($urandom_range(0, 4) == 0);
            end
            re = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            apply(row, col, cp, nb, vis, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 49) == 0), re);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
